f8_alu_writeback: RTL and testbench
===================================

# f8_alu_writeback

Commit stage that sits downstream of the f8 ALU. It accepts one ALU result per handshake: the register-side value, the memory-side value, the four flags and a destination descriptor. It performs the register-file write, updates the architectural flag register under a mask, and sequences byte-wide memory stores (two beats for 16-bit data). The registered carry is fed back to the ALU as its carry input.

## Interface
- No parameters; all widths are fixed by the f8 ISA.
- clk  in  1  single clock; all state changes on its rising edge
- reset_n  in  1  asynchronous, active-low reset
- wb_valid  in  1  ALU result and descriptor present
- wb_ready  out  1  block can accept; high only in IDLE
- result_reg  in  16  value for the register file
- result_mem  in  16  value for memory
- o_in, z_in, n_in, c_in  in  1 each  ALU flags
- flag_mask  in  4  per-flag update enable, order {O,N,Z,C}
- wide  in  1  16-bit operation (register and memory)
- reg_en  in  1  write register file
- reg_idx  in  3  destination register
- mem_en  in  1  store result_mem
- mem_addr_in  in  16  store address (low byte)
- fl_we  in  1  direct flag-register load (pop/xch flags)
- fl_wdata  in  4  value for the direct load, order {O,N,Z,C}
- rf_we  out  1  one-cycle register write strobe
- rf_idx  out  3  register index
- rf_wide  out  1  16-bit write
- rf_data  out  16  write data
- mem_req  out  1  byte store request
- mem_addr  out  16  byte address
- mem_wdata  out  8  byte data
- mem_ack  in  1  store beat accepted
- flags  out  4  architectural {O,N,Z,C}
- carry_fb  out  1  equals flags[0]; drives the ALU carry input

## Operation
- States: IDLE, MEM_LO, MEM_HI.
- An accept occurs when wb_valid && wb_ready.
- On accept:
  - Latch rf_idx, rf_wide and rf_data.
  - Assert rf_we for exactly one cycle if reg_en=1.
  - Flag bits with flag_mask=1 load from the inputs; bits with flag_mask=0 hold.
  - If mem_en=1: latch the address, result_mem and wide, then go to MEM_LO. Otherwise stay in IDLE.
- MEM_LO:
  - mem_req=1, mem_addr=latched address, mem_wdata=data[7:0].
  - On mem_ack: go to MEM_HI if wide, else to IDLE.
- MEM_HI:
  - mem_req=1, mem_addr=latched address+1 (16-bit wrap: 0xFFFF → 0x0000), mem_wdata=data[15:8].
  - On mem_ack: go to IDLE.
- Outputs are stable while mem_req=1 and mem_ack=0; mem_req never drops without an ack.
- Narrow register writes: rf_data[15:8] is driven as 0 when wide=0.
- fl_we loads all four flags from fl_wdata. If fl_we and a masked accept happen in the same cycle, fl_we wins entirely.
- fl_we is honoured in any state.
- When mem_en=0 and reg_en=0, the accept still updates flags; this is used for compare-type operations.

## Timing
- Reset values: state=IDLE, wb_ready=1, rf_we=0, rf_idx=0, rf_wide=0, rf_data=0, mem_req=0, mem_addr=0, mem_wdata=0, flags=0, carry_fb=0.
- Accept at edge N:
  - rf_we high during cycle N+1.
  - New flags and carry_fb visible from N+1, so the next ALU op can use the carry back-to-back.
  - mem_req high from N+1.
- Throughput:
  - Ops without a store: one per cycle.
  - Narrow store: one cycle plus ack wait.
  - Wide store: two beats plus ack waits.
- wb_ready is combinational from state only, never from wb_valid.
- A zero-wait slave (mem_ack tied high) gives mem_req for exactly 1 cycle (narrow) or 2 cycles (wide).
- Asserting reset_n low mid-store drops mem_req immediately and the store is lost. Callers treat this as acceptable because reset aborts the instruction.

## Structure
- Shared package f8_pkg holds:
  - wb_state_t enum {WB_IDLE, WB_MEM_LO, WB_MEM_HI}.
  - Flag bit constants FLAG_C=0, FLAG_Z=1, FLAG_N=2, FLAG_O=3.
  - aluinst_t, shared with the ALU.
- One sub-module, f8_flag_reg: a 4-bit register with mask load and direct-load priority. It is reused by the interrupt save/restore logic.
- The store sequencer stays inline.

## Test plan
- Reset, then accept {reg_en=1, reg_idx=2, wide=0, result_reg=0x12AB, flag_mask=0xF, c_in=1} → cycle N+1: rf_we=1, rf_data=0x00AB, flags=0b0001, carry_fb=1, wb_ready stays 1.
- Wide store: result_mem=0xBEEF, mem_addr_in=0x4000, mem_ack tied 1 → beats (0x4000,0xEF) then (0x4001,0xBE); wb_ready low for exactly 2 cycles.
- Wrap: wide store at 0xFFFF, ack delayed 3 cycles per beat → second beat at 0x0000; mem_addr and mem_wdata stable during the waits.
- Mask: flags=0xF, accept flag_mask=0b0010 with z_in=0 → flags=0xD; the same cycle with fl_we=1 and fl_wdata=0x3 → flags=0x3.
- Back-to-back: three narrow reg-only accepts on consecutive cycles → three consecutive rf_we pulses with matching data.
- Assert reset_n low during MEM_HI wait → mem_req=0 and state IDLE immediately; flags=0 and wb_ready=1 after release.

Source files
------------

// File: rtl/f8_pkg.sv
// Shared f8 types: writeback FSM states, flag bit positions, ALU instruction word.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package f8_pkg;

   typedef enum logic [1:0] {
      WB_IDLE   = 2'd0,
      WB_MEM_LO = 2'd1,
      WB_MEM_HI = 2'd2
   } wb_state_t;

   // Bit positions inside the 4-bit {O,N,Z,C} flag vector
   localparam int FLAG_C = 0;
   localparam int FLAG_Z = 1;
   localparam int FLAG_N = 2;
   localparam int FLAG_O = 3;

   // Decoded ALU instruction, shared between the ALU and its writeback stage
   typedef struct packed {
      logic [3:0] op;
      logic       wide;
      logic [2:0] dst;
      logic [2:0] src;
      logic       use_carry;
      logic [3:0] flag_mask;
   } aluinst_t;

endpackage

// File: rtl/f8_flag_reg.sv
// 4-bit {O,N,Z,C} flag register: masked load plus a direct load that overrides it.
// Latency: 1 cycle from load to q.
// Backpressure: none, every load is taken on the edge it is presented.
// Ports: ld_en/ld_mask/ld_data = per-bit masked update; dl_we/dl_data = full
//        direct load (wins over the masked update); q = current flags.
module f8_flag_reg (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       ld_en,
   input  logic [3:0] ld_mask,
   input  logic [3:0] ld_data,
   input  logic       dl_we,
   input  logic [3:0] dl_data,
   output logic [3:0] q
);

   logic [3:0] q_nxt;

   always_comb begin
      q_nxt = q;
      if (dl_we)
         q_nxt = dl_data;
      else if (ld_en)
         q_nxt = (q & ~ld_mask) | (ld_data & ld_mask);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         q <= 4'h0;
      else
         q <= q_nxt;
   end

endmodule

// File: rtl/f8_alu_writeback.sv
// f8 ALU commit stage: register write strobe, masked flag update, byte-wide store sequencer.
// Latency: accept at edge N gives rf_we, flags and mem_req from cycle N+1.
// Backpressure: wb_ready is high only in IDLE; a store holds it low until the last beat is acked.
// Ports: wb_valid/wb_ready handshake with result_reg/result_mem/flags/descriptor in;
//        rf_* register write out; mem_req/mem_addr/mem_wdata/mem_ack store port;
//        flags/carry_fb architectural flags, fl_we/fl_wdata direct flag load.
module f8_alu_writeback
   import f8_pkg::*;
(
   input  logic        clk,
   input  logic        reset_n,
   input  logic        wb_valid,
   output logic        wb_ready,
   input  logic [15:0] result_reg,
   input  logic [15:0] result_mem,
   input  logic        o_in,
   input  logic        z_in,
   input  logic        n_in,
   input  logic        c_in,
   input  logic [3:0]  flag_mask,
   input  logic        wide,
   input  logic        reg_en,
   input  logic [2:0]  reg_idx,
   input  logic        mem_en,
   input  logic [15:0] mem_addr_in,
   input  logic        fl_we,
   input  logic [3:0]  fl_wdata,
   output logic        rf_we,
   output logic [2:0]  rf_idx,
   output logic        rf_wide,
   output logic [15:0] rf_data,
   output logic        mem_req,
   output logic [15:0] mem_addr,
   output logic [7:0]  mem_wdata,
   input  logic        mem_ack,
   output logic [3:0]  flags,
   output logic        carry_fb
);

   wb_state_t  state, state_nxt;
   logic       accept;
   logic       st_wide;
   logic [7:0] st_hi;

   assign accept = wb_valid && wb_ready;

   // ---------------- store sequencer FSM ----------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         state <= WB_IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         WB_IDLE:   if (accept && mem_en) state_nxt = WB_MEM_LO;
         WB_MEM_LO: if (mem_ack) state_nxt = st_wide ? WB_MEM_HI : WB_IDLE;
         WB_MEM_HI: if (mem_ack) state_nxt = WB_IDLE;
         default:   state_nxt = WB_IDLE;
      endcase
   end

   // Ready and request depend on state only, so mem_req drops with async reset
   always_comb begin
      wb_ready = (state == WB_IDLE);
      mem_req  = (state == WB_MEM_LO) || (state == WB_MEM_HI);
   end

   // ---------------- register write and store datapath ----------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rf_we     <= 1'b0;
         rf_idx    <= 3'd0;
         rf_wide   <= 1'b0;
         rf_data   <= 16'h0000;
         mem_addr  <= 16'h0000;
         mem_wdata <= 8'h00;
         st_wide   <= 1'b0;
         st_hi     <= 8'h00;
      end else begin
         rf_we <= accept && reg_en;
         if (accept) begin
            rf_idx  <= reg_idx;
            rf_wide <= wide;
            rf_data <= wide ? result_reg : {8'h00, result_reg[7:0]};
            if (mem_en) begin
               mem_addr  <= mem_addr_in;
               mem_wdata <= result_mem[7:0];
               st_wide   <= wide;
               st_hi     <= result_mem[15:8];
            end
         end
         // Low beat acked on a wide store: step to the high byte (address wraps at 16 bits)
         if ((state == WB_MEM_LO) && mem_ack && st_wide) begin
            mem_addr  <= mem_addr + 16'd1;
            mem_wdata <= st_hi;
         end
      end
   end

   // ---------------- architectural flags ----------------
   f8_flag_reg u_flag_reg (
      .clk     (clk),
      .reset_n (reset_n),
      .ld_en   (accept),
      .ld_mask (flag_mask),
      .ld_data ({o_in, n_in, z_in, c_in}),
      .dl_we   (fl_we),
      .dl_data (fl_wdata),
      .q       (flags)
   );

   assign carry_fb = flags[FLAG_C];

endmodule

// File: tb/tb_f8_alu_writeback.sv
module tb_f8_alu_writeback;

   logic        clk;
   logic        reset_n;
   logic        wb_valid;
   logic        wb_ready;
   logic [15:0] result_reg;
   logic [15:0] result_mem;
   logic        o_in, z_in, n_in, c_in;
   logic [3:0]  flag_mask;
   logic        wide;
   logic        reg_en;
   logic [2:0]  reg_idx;
   logic        mem_en;
   logic [15:0] mem_addr_in;
   logic        fl_we;
   logic [3:0]  fl_wdata;
   logic        rf_we;
   logic [2:0]  rf_idx;
   logic        rf_wide;
   logic [15:0] rf_data;
   logic        mem_req;
   logic [15:0] mem_addr;
   logic [7:0]  mem_wdata;
   logic        mem_ack;
   logic [3:0]  flags;
   logic        carry_fb;

   int total;
   int bad;

   f8_alu_writeback dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .wb_valid    (wb_valid),
      .wb_ready    (wb_ready),
      .result_reg  (result_reg),
      .result_mem  (result_mem),
      .o_in        (o_in),
      .z_in        (z_in),
      .n_in        (n_in),
      .c_in        (c_in),
      .flag_mask   (flag_mask),
      .wide        (wide),
      .reg_en      (reg_en),
      .reg_idx     (reg_idx),
      .mem_en      (mem_en),
      .mem_addr_in (mem_addr_in),
      .fl_we       (fl_we),
      .fl_wdata    (fl_wdata),
      .rf_we       (rf_we),
      .rf_idx      (rf_idx),
      .rf_wide     (rf_wide),
      .rf_data     (rf_data),
      .mem_req     (mem_req),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .mem_ack     (mem_ack),
      .flags       (flags),
      .carry_fb    (carry_fb)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // fin and fl_wdata in {O,N,Z,C} order
   typedef struct {
      logic        reg_en;
      logic [2:0]  idx;
      logic        wide;
      logic [15:0] rr;
      logic [3:0]  mask;
      logic [3:0]  fin;
      logic        fl_we;
      logic [3:0]  fl_wdata;
      logic        e_we;
      logic [15:0] e_data;
      logic [3:0]  e_flags;
   } vec_t;

   vec_t vt [8];

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   // Step to just after the next rising edge
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic clr_in();
      wb_valid    = 1'b0;
      result_reg  = 16'h0;
      result_mem  = 16'h0;
      {o_in, n_in, z_in, c_in} = 4'h0;
      flag_mask   = 4'h0;
      wide        = 1'b0;
      reg_en      = 1'b0;
      reg_idx     = 3'd0;
      mem_en      = 1'b0;
      mem_addr_in = 16'h0;
      fl_we       = 1'b0;
      fl_wdata    = 4'h0;
      mem_ack     = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      total = 0;
      bad   = 0;
      //          reg idx  wide rr        mask  fin   flwe flwd  we  data      flags
      vt[0] = '{1'b1, 3'd2, 1'b0, 16'h12AB, 4'hF, 4'h1, 1'b0, 4'h0, 1'b1, 16'h00AB, 4'h1};
      vt[1] = '{1'b1, 3'd5, 1'b0, 16'hBEEF, 4'hF, 4'hC, 1'b0, 4'h0, 1'b1, 16'h00EF, 4'hC};
      vt[2] = '{1'b1, 3'd7, 1'b0, 16'hFF80, 4'h1, 4'hF, 1'b0, 4'h0, 1'b1, 16'h0080, 4'hD};
      vt[3] = '{1'b0, 3'd3, 1'b0, 16'h0055, 4'h2, 4'h2, 1'b0, 4'h0, 1'b0, 16'h0055, 4'hF};
      vt[4] = '{1'b1, 3'd1, 1'b1, 16'h1234, 4'h2, 4'h0, 1'b0, 4'h0, 1'b1, 16'h1234, 4'hD};
      vt[5] = '{1'b1, 3'd4, 1'b0, 16'hA5A5, 4'h2, 4'h0, 1'b1, 4'h3, 1'b1, 16'h00A5, 4'h3};
      vt[6] = '{1'b0, 3'd0, 1'b0, 16'h0000, 4'h0, 4'h0, 1'b1, 4'h0, 1'b0, 16'h0000, 4'h0};
      vt[7] = '{1'b1, 3'd6, 1'b1, 16'h8001, 4'hF, 4'hA, 1'b0, 4'h0, 1'b1, 16'h8001, 4'hA};

      clr_in();
      reset_n = 1'b0;
      repeat (3) cyc();
      reset_n = 1'b1;
      #1;
      chk("rst_rf_we",     16'(rf_we),     16'h0);
      chk("rst_rf_idx",    16'(rf_idx),    16'h0);
      chk("rst_rf_wide",   16'(rf_wide),   16'h0);
      chk("rst_rf_data",   rf_data,        16'h0);
      chk("rst_mem_req",   16'(mem_req),   16'h0);
      chk("rst_mem_addr",  mem_addr,       16'h0);
      chk("rst_mem_wdata", 16'(mem_wdata), 16'h0);
      chk("rst_flags",     16'(flags),     16'h0);
      chk("rst_carry_fb",  16'(carry_fb),  16'h0);
      chk("rst_wb_ready",  16'(wb_ready),  16'h1);

      // Table: one accept per cycle, back-to-back, flags chain from vector to vector
      for (int i = 0; i < 8; i++) begin
         wb_valid   = 1'b1;
         reg_en     = vt[i].reg_en;
         reg_idx    = vt[i].idx;
         wide       = vt[i].wide;
         result_reg = vt[i].rr;
         flag_mask  = vt[i].mask;
         {o_in, n_in, z_in, c_in} = vt[i].fin;
         fl_we      = vt[i].fl_we;
         fl_wdata   = vt[i].fl_wdata;
         cyc();
         chk($sformatf("v%0d_rf_we", i),    16'(rf_we),    16'(vt[i].e_we));
         chk($sformatf("v%0d_rf_idx", i),   16'(rf_idx),   16'(vt[i].idx));
         chk($sformatf("v%0d_rf_wide", i),  16'(rf_wide),  16'(vt[i].wide));
         chk($sformatf("v%0d_rf_data", i),  rf_data,       vt[i].e_data);
         chk($sformatf("v%0d_flags", i),    16'(flags),    16'(vt[i].e_flags));
         chk($sformatf("v%0d_carry", i),    16'(carry_fb), 16'(vt[i].e_flags[0]));
         chk($sformatf("v%0d_wb_ready", i), 16'(wb_ready), 16'h1);
         chk($sformatf("v%0d_mem_req", i),  16'(mem_req),  16'h0);
      end
      clr_in();
      cyc();
      chk("strobe_drop_rf_we", 16'(rf_we), 16'h0);
      chk("idle_flags_hold",   16'(flags), 16'hA);

      // Narrow store, zero-wait slave, together with a register write
      wb_valid = 1'b1; mem_en = 1'b1; reg_en = 1'b1; reg_idx = 3'd2;
      result_reg = 16'h0042; result_mem = 16'h7766; mem_addr_in = 16'h1000;
      mem_ack = 1'b1;
      cyc();
      wb_valid = 1'b0;
      chk("ns_mem_req",   16'(mem_req),   16'h1);
      chk("ns_mem_addr",  mem_addr,       16'h1000);
      chk("ns_mem_wdata", 16'(mem_wdata), 16'h66);
      chk("ns_rf_we",     16'(rf_we),     16'h1);
      chk("ns_wb_ready",  16'(wb_ready),  16'h0);
      cyc();
      chk("ns_done_req",   16'(mem_req),  16'h0);
      chk("ns_done_ready", 16'(wb_ready), 16'h1);
      chk("ns_flags_held", 16'(flags),    16'hA);

      // Wide store, zero-wait slave: two beats, ready low for exactly two cycles
      clr_in();
      wb_valid = 1'b1; mem_en = 1'b1; wide = 1'b1;
      result_mem = 16'hBEEF; mem_addr_in = 16'h4000; mem_ack = 1'b1;
      cyc();
      chk("ws_b0_req",   16'(mem_req),   16'h1);
      chk("ws_b0_addr",  mem_addr,       16'h4000);
      chk("ws_b0_data",  16'(mem_wdata), 16'hEF);
      chk("ws_b0_ready", 16'(wb_ready),  16'h0);
      wb_valid = 1'b0;
      cyc();
      chk("ws_b1_req",   16'(mem_req),   16'h1);
      chk("ws_b1_addr",  mem_addr,       16'h4001);
      chk("ws_b1_data",  16'(mem_wdata), 16'hBE);
      chk("ws_b1_ready", 16'(wb_ready),  16'h0);
      cyc();
      chk("ws_end_req",   16'(mem_req),  16'h0);
      chk("ws_end_ready", 16'(wb_ready), 16'h1);

      // Wide store at 0xFFFF with a 3-cycle ack delay per beat; fl_we during the wait
      clr_in();
      wb_valid = 1'b1; mem_en = 1'b1; wide = 1'b1;
      result_mem = 16'h1357; mem_addr_in = 16'hFFFF;
      cyc();
      wb_valid = 1'b0;
      fl_we = 1'b1; fl_wdata = 4'h9;
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("wr_lo%0d_req", k),  16'(mem_req),   16'h1);
         chk($sformatf("wr_lo%0d_addr", k), mem_addr,       16'hFFFF);
         chk($sformatf("wr_lo%0d_data", k), 16'(mem_wdata), 16'h57);
         cyc();
         fl_we = 1'b0;
      end
      chk("wr_fl_we_in_store", 16'(flags), 16'h9);
      chk("wr_carry_fb",       16'(carry_fb), 16'h1);
      mem_ack = 1'b1;
      cyc();
      mem_ack = 1'b0;
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("wr_hi%0d_req", k),  16'(mem_req),   16'h1);
         chk($sformatf("wr_hi%0d_addr", k), mem_addr,       16'h0000);
         chk($sformatf("wr_hi%0d_data", k), 16'(mem_wdata), 16'h13);
         chk($sformatf("wr_hi%0d_ready", k), 16'(wb_ready), 16'h0);
         cyc();
      end
      mem_ack = 1'b1;
      cyc();
      mem_ack = 1'b0;
      chk("wr_end_req",   16'(mem_req),  16'h0);
      chk("wr_end_ready", 16'(wb_ready), 16'h1);

      // Reset asserted while waiting on the high beat
      clr_in();
      wb_valid = 1'b1; mem_en = 1'b1; wide = 1'b1;
      result_mem = 16'h2468; mem_addr_in = 16'h0100;
      cyc();
      wb_valid = 1'b0; mem_ack = 1'b1;
      cyc();
      mem_ack = 1'b0;
      cyc();
      chk("ra_pre_req",  16'(mem_req), 16'h1);
      chk("ra_pre_addr", mem_addr,     16'h0101);
      reset_n = 1'b0;
      #1;
      chk("ra_req_now",   16'(mem_req),  16'h0);
      chk("ra_ready_now", 16'(wb_ready), 16'h1);
      repeat (2) cyc();
      reset_n = 1'b1;
      cyc();
      chk("ra_post_flags", 16'(flags),    16'h0);
      chk("ra_post_ready", 16'(wb_ready), 16'h1);
      chk("ra_post_req",   16'(mem_req),  16'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
